ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter: accepts one command byte per handshake and serialises it onto the open-collector PS/2 clock/data lines. It performs the inhibit, request-to-send, 11-bit frame, and acknowledge sequence. It is the transmit companion of the keyboard receive path: it sends commands such as 0xED (set LEDs) and 0xF4 (enable) from the controller logic to the keyboard, and it sits beside the receiver at the board PS/2 pins.

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_sync_edge.sv | 33 +++
 rtl/ps2_host_tx.sv | 164 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM states, frame geometry and the microsecond-to-cycle helper.
// Used by both the host transmitter and the keyboard receive path.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        BITS,
        ACK,
        WAIT_IDLE
    } ps2_state_t;

    localparam int DATA_BITS   = 8;
    localparam int FRAME_EDGES = 11;

    function automatic int us_to_cycles(input int clk_hz, input int us);
        return (clk_hz / 1_000_000) * us;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchroniser for a raw PS/2 pin plus a registered falling-edge pulse.
// Latency pin-to-fall_o is 3 clocks; sync flops reset high to match the idle bus.
module ps2_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic pin_i,
    output logic level_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic fall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
            fall_q <= 1'b0;
        end else begin
            meta_q <= pin_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            fall_q <= prev_q & ~sync_q;
        end
    end

    assign level_o = sync_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 11-edge frame, ack check, watchdog.
// Accepts one byte when tx_ready is high (IDLE only); offers while busy are ignored, not queued.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int INHIBIT_US = 100,
    parameter int TIMEOUT_US = 15000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout_err
);

    localparam int INHIBIT_CYC = us_to_cycles(CLK_HZ, INHIBIT_US);
    localparam int TIMEOUT_CYC = us_to_cycles(CLK_HZ, TIMEOUT_US);
    localparam int INH_W       = $clog2(INHIBIT_CYC);
    localparam int WD_W        = $clog2(TIMEOUT_CYC);

    logic clk_lvl, clk_fall;
    logic data_lvl, data_fall;

    ps2_sync_edge u_clk_sync (
        .clk     (clk),
        .rst     (rst),
        .pin_i   (ps2_clk_in),
        .level_o (clk_lvl),
        .fall_o  (clk_fall)
    );

    ps2_sync_edge u_data_sync (
        .clk     (clk),
        .rst     (rst),
        .pin_i   (ps2_data_in),
        .level_o (data_lvl),
        .fall_o  (data_fall)
    );

    ps2_state_t       state_q;
    logic [7:0]       byte_q;
    logic             parity_q;
    logic [3:0]       bit_idx_q;
    logic [INH_W-1:0] inh_cnt_q;
    logic [WD_W-1:0]  wd_cnt_q;
    logic             tx_ready_q, clk_oe_q, data_oe_q, busy_q, done_q;
    logic             ack_err_q, timeout_err_q;
    logic             wd_active;

    assign wd_active = (state_q == REQ) || (state_q == BITS) ||
                       (state_q == ACK) || (state_q == WAIT_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            byte_q        <= '0;
            parity_q      <= 1'b0;
            bit_idx_q     <= '0;
            inh_cnt_q     <= '0;
            wd_cnt_q      <= '0;
            tx_ready_q    <= 1'b1;
            clk_oe_q      <= 1'b0;
            data_oe_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            ack_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (wd_active) begin
                wd_cnt_q <= wd_cnt_q + 1'b1;
            end
            if (wd_active && (wd_cnt_q == WD_W'(TIMEOUT_CYC - 1))) begin
                clk_oe_q      <= 1'b0;
                data_oe_q     <= 1'b0;
                timeout_err_q <= 1'b1;
                done_q        <= 1'b1;
                busy_q        <= 1'b0;
                tx_ready_q    <= 1'b1;
                state_q       <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (tx_valid && tx_ready_q) begin
                            byte_q        <= tx_data;
                            parity_q      <= ~^tx_data;
                            ack_err_q     <= 1'b0;
                            timeout_err_q <= 1'b0;
                            tx_ready_q    <= 1'b0;
                            busy_q        <= 1'b1;
                            clk_oe_q      <= 1'b1;
                            inh_cnt_q     <= '0;
                            state_q       <= INHIBIT;
                        end
                    end
                    INHIBIT: begin
                        inh_cnt_q <= inh_cnt_q + 1'b1;
                        // start bit goes low one cycle before the clock is released
                        if (inh_cnt_q == INH_W'(INHIBIT_CYC - 2)) begin
                            data_oe_q <= 1'b1;
                        end
                        if (inh_cnt_q == INH_W'(INHIBIT_CYC - 1)) begin
                            clk_oe_q <= 1'b0;
                            wd_cnt_q <= '0;
                            state_q  <= REQ;
                        end
                    end
                    REQ: begin
                        bit_idx_q <= '0;
                        state_q   <= BITS;
                    end
                    BITS: begin
                        if (clk_fall) begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                            if (bit_idx_q < 4'(DATA_BITS)) begin
                                data_oe_q <= ~byte_q[bit_idx_q[2:0]];
                            end else if (bit_idx_q == 4'(DATA_BITS)) begin
                                data_oe_q <= ~parity_q;
                            end else begin
                                data_oe_q <= 1'b0;
                                state_q   <= ACK;
                            end
                        end
                    end
                    ACK: begin
                        if (clk_fall) begin
                            ack_err_q <= data_lvl;
                            bit_idx_q <= 4'(FRAME_EDGES);
                            state_q   <= WAIT_IDLE;
                        end
                    end
                    WAIT_IDLE: begin
                        // a data fall still in the pipe means the device has not let go yet
                        if (clk_lvl && data_lvl && !data_fall) begin
                            done_q     <= 1'b1;
                            busy_q     <= 1'b0;
                            tx_ready_q <= 1'b1;
                            state_q    <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign tx_ready    = tx_ready_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign ack_err     = ack_err_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a wired-AND PS/2 bus and a 40-cycle device clock model.
module tb_ps2_host_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       busy, done, ack_err, timeout_err;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       clk_line, data_line;

    int tests = 0;
    int fails = 0;

    assign clk_line  = dev_clk & ~ps2_clk_oe;
    assign data_line = dev_data & ~ps2_data_oe;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .CLK_HZ     (1_000_000),
        .INHIBIT_US (100),
        .TIMEOUT_US (15000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .ps2_clk_in  (clk_line),
        .ps2_data_in (data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .done        (done),
        .ack_err     (ack_err),
        .timeout_err (timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("accept_busy", busy, 1);
        check("accept_clk_oe", ps2_clk_oe, 1);
    endtask

    // Device side: wait for request-to-send, then clock out 11 edges, sampling on rising edges.
    task automatic dev_run(input bit do_ack, input int rst_at, output logic [9:0] got);
        bit found = 0;
        got = '0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (clk_line && !data_line) begin
                found = 1;
                break;
            end
        end
        check("rts_seen", found, 1);
        if (!found) return;
        repeat (10) @(negedge clk);
        for (int k = 1; k <= 11; k++) begin
            dev_clk = 1'b0;
            if (k == rst_at) begin
                repeat (5) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                dev_clk = 1'b1;
                check("rst_clk_oe", ps2_clk_oe, 0);
                check("rst_data_oe", ps2_data_oe, 0);
                check("rst_tx_ready", tx_ready, 1);
                check("rst_busy", busy, 0);
                return;
            end
            repeat (20) @(negedge clk);
            dev_clk = 1'b1;
            if (k <= 10) got[k-1] = data_line;
            if (k == 10 && do_ack) dev_data = 1'b0;
            if (k == 11) dev_data = 1'b1;
            if (k < 11) repeat (20) @(negedge clk);
        end
    endtask

    task automatic wait_done(input int limit);
        bit seen = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        check("done_seen", seen, 1);
    endtask

    task automatic end_checks(input bit exp_ack, input bit exp_to);
        check("ack_err", ack_err, 32'(exp_ack));
        check("timeout_err", timeout_err, 32'(exp_to));
        check("end_clk_oe", ps2_clk_oe, 0);
        check("end_data_oe", ps2_data_oe, 0);
        check("end_tx_ready", tx_ready, 1);
    endtask

    logic [9:0] got;
    int n_inh, n_dat, cnt, n_done;
    bit found;

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_tx_ready0", tx_ready, 1);
        check("rst_clk_oe0", ps2_clk_oe, 0);
        check("rst_data_oe0", ps2_data_oe, 0);
        check("rst_busy0", busy, 0);
        check("rst_done0", done, 0);
        check("rst_errs0", {ack_err, timeout_err}, 0);

        // device-to-host clocking while idle must not start anything
        for (int i = 0; i < 3; i++) begin
            dev_clk = 1'b0; repeat (20) @(negedge clk);
            dev_clk = 1'b1; repeat (20) @(negedge clk);
        end
        check("idle_edges_busy", busy, 0);
        check("idle_edges_oe", {ps2_clk_oe, ps2_data_oe}, 0);

        // 0xED with inhibit timing measured
        send(8'hED);
        n_inh = 1;
        n_dat = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!ps2_clk_oe) break;
            n_inh++;
            if (ps2_data_oe) n_dat++;
        end
        check("inhibit_len", n_inh, 100);
        check("start_lead_cycles", n_dat, 1);
        check("req_data_oe", ps2_data_oe, 1);
        dev_run(1, 0, got);
        check("ed_data", got[7:0], 8'hED);
        check("ed_parity", got[8], 1);
        check("ed_stop", got[9], 1);
        wait_done(200);
        end_checks(0, 0);
        @(negedge clk);
        check("done_one_cycle", done, 0);

        send(8'hF4);
        dev_run(1, 0, got);
        check("f4_data", got[7:0], 8'hF4);
        check("f4_parity", got[8], 0);
        wait_done(200);
        end_checks(0, 0);

        send(8'h00);
        dev_run(1, 0, got);
        check("00_data", got[7:0], 8'h00);
        check("00_parity", got[8], 1);
        wait_done(200);
        end_checks(0, 0);

        send(8'hFF);
        dev_run(1, 0, got);
        check("ff_data", got[7:0], 8'hFF);
        check("ff_parity", got[8], 1);
        wait_done(200);
        end_checks(0, 0);

        // no acknowledge
        send(8'h12);
        dev_run(0, 0, got);
        check("nak_data", got[7:0], 8'h12);
        wait_done(200);
        end_checks(1, 0);

        // device never clocks: watchdog from REQ entry
        send(8'hF4);
        check("nak_cleared", ack_err, 0);
        found = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!ps2_clk_oe) begin
                found = 1;
                break;
            end
        end
        check("req_reached", found, 1);
        cnt = 0;
        for (int i = 0; i < 16000; i++) begin
            @(negedge clk);
            cnt++;
            if (done) break;
        end
        check("timeout_cycles", cnt, 15000);
        check("timeout_done", done, 1);
        end_checks(0, 1);

        // reset mid-frame at the 5th falling edge
        send(8'h5A);
        dev_run(1, 5, got);
        n_done = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("rst_no_done", n_done, 0);
        check("rst_errs_clr", {ack_err, timeout_err}, 0);
        send(8'hF4);
        dev_run(1, 0, got);
        check("post_rst_data", got[7:0], 8'hF4);
        wait_done(200);
        end_checks(0, 0);

        // tx_valid held with a new byte during a transaction
        @(negedge clk);
        tx_data  = 8'hF4;
        tx_valid = 1'b1;
        @(negedge clk);
        check("hold_busy", busy, 1);
        tx_data = 8'hAA;
        dev_run(1, 0, got);
        check("hold_first_data", got[7:0], 8'hF4);
        wait_done(200);
        check("hold_ready_at_done", tx_ready, 1);
        @(negedge clk);
        tx_valid = 1'b0;
        check("hold_aa_accepted", busy, 1);
        check("hold_ready_low", tx_ready, 0);
        dev_run(1, 0, got);
        check("aa_data", got[7:0], 8'hAA);
        check("aa_parity", got[8], 1);
        wait_done(200);
        end_checks(0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
